// File: rtl/ifu_fetch_queue_if.sv
// Instruction-memory request/response bundle between the fetch queue and imem.
// The master side is the fetch unit, the slave side is the memory.
interface ifu_fetch_queue_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [31:0]     resp_instr;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_instr
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_instr
    );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Pipelined instruction fetch unit: issues sequential fetches with up to DEPTH
// outstanding, buffers in-order responses in a DEPTH-entry queue and feeds the
// IF/ID register. Redirects discard queued and still-outstanding fetches.
module ifu_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h80000000,
    parameter int              DEPTH    = 4,
    parameter logic [31:0]     NOP      = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 jump_en,
    input  logic [XLEN-1:0]      jump_pc,
    ifu_fetch_queue_if.master    imem,
    input  logic                 hazard_stop,
    input  logic                 flush_nop,
    output logic [XLEN-1:0]      ifu_pc,
    output logic [31:0]          ifu_instr,
    output logic [XLEN-1:0]      ifu_snxt_pc,
    output logic                 ifu_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];

    logic [CW:0]     occupancy;
    logic            fire;
    logic            resp_ok;
    logic            push;
    logic            pop;
    logic            bubble;
    logic [XLEN-1:0] bubble_pc;

    // Outstanding fetches plus buffered entries never exceed DEPTH, so every
    // response that returns is guaranteed a free queue slot.
    assign occupancy      = {1'b0, inflight} + {1'b0, count};
    assign imem.req_valid = !jump_en && (occupancy < (CW+1)'(DEPTH));
    assign imem.req_addr  = fetch_pc;
    assign fire           = imem.req_valid && imem.req_ready;
    assign resp_ok        = imem.resp_valid && (inflight != '0);
    assign push           = resp_ok && !jump_en && (discard == '0);
    assign pop            = !jump_en && !flush_nop && !hazard_stop && (count != '0);
    assign bubble         = jump_en || flush_nop || (!hazard_stop && (count == '0));
    assign bubble_pc      = jump_en ? jump_pc : resp_pc;

    // Fetch/response pointers, in-flight and discard accounting, queue pointers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(resp_ok);
            if (jump_en) begin
                fetch_pc <= jump_pc;
                resp_pc  <= jump_pc;
                discard  <= inflight - CW'(resp_ok);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (resp_ok && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imem.resp_instr;
        end
    end

    // IF/ID register: redirect/flush bubble, then stall hold, then pop, else bubble.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ifu_pc      <= '0;
            ifu_instr   <= '0;
            ifu_snxt_pc <= '0;
            ifu_valid   <= 1'b0;
        end else if (bubble) begin
            ifu_pc      <= bubble_pc;
            ifu_instr   <= NOP;
            ifu_snxt_pc <= bubble_pc + XLEN'(4);
            ifu_valid   <= 1'b0;
        end else if (pop) begin
            ifu_pc      <= q_pc[rd_ptr];
            ifu_instr   <= q_instr[rd_ptr];
            ifu_snxt_pc <= q_pc[rd_ptr] + XLEN'(4);
            ifu_valid   <= 1'b1;
        end
    end

    // A response with nothing outstanding indicates a misbehaving memory.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(imem.resp_valid && (inflight == '0)));
        end
    end
endmodule
